// File: rtl/c_mutex_split2_sync.sv
// -----------------------------------------------------------------------------
// c_mutex_split2_sync
//
// Two-way split mutex. One upstream requester hands a payload to one of two
// downstream branches and waits until that branch releases it before the
// upstream side is released. Only one transaction can be in flight at a time.
//
// Parameters
//   DATA_W     payload width
//   FREE_DELAY cycles from an accepted branch release to o_free (1..15)
//   CNT_W      width of the per-branch completed-transaction counters
//
// Ports
//   clk, rst             clock and synchronous active-high reset
//   i_drive/i_sel/i_data upstream request pulse, branch select and payload
//   o_free               upstream release pulse
//   o_drive0/o_drive1    branch request pulses (one cycle after acceptance)
//   o_data0/o_data1      branch payloads, held from o_driveN until o_free
//   i_free0/i_free1      branch release pulses
//   o_busy               high whenever a transaction is in flight
//   o_err                sticky protocol-violation flag, cleared only by rst
//   o_cnt0/o_cnt1        completed transactions per branch (wrapping)
// -----------------------------------------------------------------------------
module c_mutex_split2_sync #(
  parameter int DATA_W     = 32,
  parameter int FREE_DELAY = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_drive,
  input  logic              i_sel,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_free,
  output logic              o_drive0,
  output logic              o_drive1,
  output logic [DATA_W-1:0] o_data0,
  output logic [DATA_W-1:0] o_data1,
  input  logic              i_free0,
  input  logic              i_free1,
  output logic              o_busy,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_cnt0,
  output logic [CNT_W-1:0]  o_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT0 = 2'd1,
    WAIT1 = 2'd2,
    REL   = 2'd3
  } state_t;

  // REL lasts FREE_DELAY-1 cycles; the countdown is loaded so that it hits
  // zero in the last REL cycle, which then schedules o_free.
  localparam logic [3:0] REL_LOAD = 4'((FREE_DELAY > 1) ? (FREE_DELAY - 2) : 0);

  state_t     state_q, state_d;
  logic [3:0] rel_q, rel_d;
  logic       drive_accept;
  logic       free_accept0;
  logic       free_accept1;
  logic       free_pulse_d;
  logic       err_event;

  // State register together with the registered output pulses, payload
  // latches, counters and the sticky error flag. Reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rel_q    <= '0;
      o_drive0 <= 1'b0;
      o_drive1 <= 1'b0;
      o_free   <= 1'b0;
      o_err    <= 1'b0;
      o_data0  <= '0;
      o_data1  <= '0;
      o_cnt0   <= '0;
      o_cnt1   <= '0;
    end else begin
      state_q  <= state_d;
      rel_q    <= rel_d;
      o_drive0 <= drive_accept & ~i_sel;
      o_drive1 <= drive_accept & i_sel;
      o_free   <= free_pulse_d;
      if (err_event)
        o_err <= 1'b1;
      if (drive_accept && !i_sel)
        o_data0 <= i_data;
      if (drive_accept && i_sel)
        o_data1 <= i_data;
      if (free_accept0)
        o_cnt0 <= o_cnt0 + CNT_W'(1);
      if (free_accept1)
        o_cnt1 <= o_cnt1 + CNT_W'(1);
    end
  end

  // Next-state logic. Any request or release that the current state cannot
  // take is dropped and only raises the error flag.
  always_comb begin
    state_d      = state_q;
    rel_d        = rel_q;
    drive_accept = 1'b0;
    free_accept0 = 1'b0;
    free_accept1 = 1'b0;
    free_pulse_d = 1'b0;
    err_event    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_free0 || i_free1)
          err_event = 1'b1;
        if (i_drive) begin
          drive_accept = 1'b1;
          state_d      = i_sel ? WAIT1 : WAIT0;
        end
      end
      WAIT0: begin
        if (i_drive || i_free1)
          err_event = 1'b1;
        if (i_free0) begin
          free_accept0 = 1'b1;
          if (FREE_DELAY == 1) begin
            state_d      = IDLE;
            free_pulse_d = 1'b1;
          end else begin
            state_d = REL;
            rel_d   = REL_LOAD;
          end
        end
      end
      WAIT1: begin
        if (i_drive || i_free0)
          err_event = 1'b1;
        if (i_free1) begin
          free_accept1 = 1'b1;
          if (FREE_DELAY == 1) begin
            state_d      = IDLE;
            free_pulse_d = 1'b1;
          end else begin
            state_d = REL;
            rel_d   = REL_LOAD;
          end
        end
      end
      REL: begin
        if (i_drive || i_free0 || i_free1)
          err_event = 1'b1;
        if (rel_q == 4'd0) begin
          state_d      = IDLE;
          free_pulse_d = 1'b1;
        end else begin
          rel_d = rel_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    o_busy = (state_q != IDLE);
  end

endmodule
